serial_adder: RTL and testbench

- Bit-serial adder. Adds two WIDTH-bit operands LSB-first, one bit per clock.
- Each bit is processed by a full-adder cell built from two half-adder stages (and/xor) plus an OR. A single carry flip-flop closes the loop between bits.
- Sits downstream of the half-adder primitive and consumes its sum/carry outputs.
- Gives the lab datapath a small, area-cheap multi-bit adder with a start/done handshake.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_fa_cell.sv | 20 ++
 rtl/serial_adder.sv | 89 ++++++++
 tb/tb_serial_adder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder built from two half-adder stages joined by an OR;
// the per-bit cell of the serial adder.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic hs1, hc1, hc2;

    // The second stage folds the incoming carry into the first partial sum.
    assign hs1 = x ^ y;
    assign hc1 = x & y;
    assign s   = hs1 ^ ci;
    assign hc2 = hs1 & ci;
    assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// with a start/busy/done handshake and registered sum/cout.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_t           state, state_next;
    logic [WIDTH-1:0] sh_a, sh_b, sh_s;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_s, fa_co;
    logic             load, last;

    // Starts are honoured only when no operation is in flight.
    assign load = start && (state == ST_IDLE || state == ST_DONE);
    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    serial_fa_cell u_fa (
        .x  (sh_a[0]),
        .y  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last)  state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // sum/cout update only on the final bit so they hold across new starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            sh_a  <= a;
            sh_b  <= b;
            sh_s  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            sh_s  <= {fa_s, sh_s[WIDTH-1:1]};
            carry <= fa_co;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                sum  <= {fa_s, sh_s[WIDTH-1:1]};
                cout <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed 8-bit vectors plus an
// exhaustive sweep of a 4-bit instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One 8-bit operation from idle: checks latency, busy length and result.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input logic [8:0] expected,
                                 input string tag);
        int n;
        int busy_cycles;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        busy_cycles = 0;
        while (!done8 && n < 40) begin
            if (busy8) busy_cycles++;
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'd9);
        checkOutput({tag, "_busy"}, 32'(busy_cycles), 32'd8);
        checkOutput({tag, "_result"}, 32'({cout8, sum8}), 32'(expected));
    endtask

    initial begin
        int n;
        bit seen_done;
        bit idle_ok;

        #12;
        checkOutput("reset_busy", 32'(busy8), 32'd0);
        checkOutput("reset_done", 32'(done8), 32'd0);
        checkOutput("reset_result", 32'({cout8, sum8}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h05, 8'h03, 1'b0, 9'h008, "add_5_3");
        applyStimulus(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_1");
        applyStimulus(8'hFF, 8'hFF, 1'b1, 9'h1FF, "add_ff_ff_c");

        // start held through RUN, operands changed mid-run, then back-to-back op
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 1;
        while (!done8 && n < 40) begin
            if (n == 4) begin
                a8 = 8'hAA; b8 = 8'h55;
            end
            @(negedge clk);
            n++;
        end
        checkOutput("hold_start_latency", 32'(n), 32'd9);
        checkOutput("hold_start_result", 32'({cout8, sum8}), 32'h030);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 40) begin
            if (n == 3) checkOutput("b2b_sum_holds", 32'({cout8, sum8}), 32'h030);
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_latency", 32'(n), 32'd9);
        checkOutput("b2b_result", 32'({cout8, sum8}), 32'h0FF);
        @(negedge clk);
        checkOutput("b2b_back_idle", 32'({busy8, done8}), 32'd0);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_abort_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy8), 32'd0);
        checkOutput("abort_done", 32'(done8), 32'd0);
        checkOutput("abort_sum", 32'(sum8), 32'd0);
        checkOutput("abort_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen_done = 1'b1;
        end
        checkOutput("abort_no_done", 32'(seen_done), 32'd0);
        applyStimulus(8'h0F, 8'h01, 1'b0, 9'h010, "after_abort");

        // idle: nothing changes without a start
        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done8 || busy8 || {cout8, sum8} != 9'h010) idle_ok = 1'b0;
        end
        checkOutput("idle_hold", 32'(idle_ok), 32'd1);

        // exhaustive 4-bit sweep
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8); start4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start4 = 1'b0;
            n = 1;
            while (!done4 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checkOutput($sformatf("w4_latency_%0d", i), 32'(n), 32'd5);
            checkOutput($sformatf("w4_result_%0d", i), 32'({cout4, sum4}),
                        32'(int'(a4) + int'(b4) + int'(cin4)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
